// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the feeder FSM state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/serializer-facing signal bundle of uart_tx_feeder.
// slave = the feeder itself, master = producer plus uart_tx side.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);
  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic                   tx_en;
  logic [UART_DATA_W-1:0] tx_din;
  logic                   tx_busy;
  logic                   busy_err;
  logic [15:0]            tx_count;

  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, level, tx_en, tx_din, busy_err, tx_count
  );

  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, level, tx_en, tx_din, busy_err, tx_count
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and synchronous flush.
// Used for the transmit queue; generic enough for the receive side too.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Push is judged against the registered full flag, so a same-cycle pop never frees room.
  assign do_push = push && !full_q && !flush;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (do_push && !do_pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!do_push && do_pop) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      full_q  <= (level_d == LVL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
endmodule

// File: rtl/uart_tx_feeder.sv
// Queues producer bytes and launches them one at a time into uart_tx.
// Build option: define UART_TX_FEEDER_CNT_EN to include the tx_count launch counter.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_tx_feeder_if.slave bus
);
  // One timer serves both WAIT_BUSY and GAP since those states never overlap.
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + GAP_CYCLES + 2);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  feeder_state_t          state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   busy_err_q, busy_err_d;
  logic                   tx_en_q;
  logic [UART_DATA_W-1:0] tx_din_q;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   pop;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (bus.wr_en),
    .pop   (pop),
    .flush (bus.flush),
    .din   (bus.wr_data),
    .dout  (fifo_dout),
    .full  (bus.full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    busy_err_d = busy_err_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LAUNCH;
      end
      LAUNCH: begin
        pop     = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMO_LAST) begin
          busy_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (timer_q == GAP_LAST) state_d = IDLE;
        else                     timer_d = timer_q + TMR_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_en/tx_din are loaded on the edge entering LAUNCH so both are flop outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      busy_err_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      busy_err_q <= busy_err_d;
      tx_en_q    <= (state_d == LAUNCH);
      if (state_d == LAUNCH) tx_din_q <= fifo_dout;
    end
  end

`ifdef UART_TX_FEEDER_CNT_EN
  logic [15:0] tx_count_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                 tx_count_q <= '0;
    else if (state_q == LAUNCH)  tx_count_q <= tx_count_q + 16'd1;
  end

  assign bus.tx_count = tx_count_q;
`else
  assign bus.tx_count = 16'h0000;
`endif

  assign bus.empty    = fifo_empty;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_din   = tx_din_q;
  assign bus.busy_err = busy_err_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized self-checking bench for uart_tx_feeder with a loopback uart_tx model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int GAP   = 5;
  localparam int TMO   = 16;
  localparam int FRAME = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus();

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int launches = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // uart_tx model: takes tx_din on tx_en, busy for FRAME cycles, then delivers it
  logic       ser_busy  = 1'b0;
  logic [7:0] ser_byte  = 8'h00;
  logic [7:0] rec_dout  = 8'h00;
  int         ser_cnt   = 0;
  bit         stuck     = 1'b0;
  bit         hold_busy = 1'b0;
  logic [7:0] rec_q[$];

  assign bus.tx_busy = ser_busy;

  always @(posedge sys_clk) begin
    if (ser_cnt > 0) begin
      if (!hold_busy) begin
        ser_cnt <= ser_cnt - 1;
        if (ser_cnt == 1) begin
          ser_busy <= 1'b0;
          rec_dout <= ser_byte;
          rec_q.push_back(ser_byte);
        end
      end
    end else if (bus.tx_en && !stuck) begin
      ser_byte <= bus.tx_din;
      ser_busy <= 1'b1;
      ser_cnt  <= FRAME;
    end
  end

  int   dbl_en  = 0;
  logic prev_en = 1'b0;
  always @(negedge sys_clk) begin
    if (bus.tx_en && prev_en) dbl_en++;
    prev_en = bus.tx_en;
  end

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef UART_TX_FEEDER_CNT_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge sys_clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
  endtask

  task automatic wait_rec(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rec_q.size() >= target) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    repeat (GAP + 3) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.tx_en !== 1'b0)     begin errors++; $display("FAIL reset_tx_en: got %b want 0", bus.tx_en); end
    checks++; if (bus.tx_din !== 8'h00)   begin errors++; $display("FAIL reset_tx_din: got %h want 00", bus.tx_din); end
    checks++; if (bus.full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.level !== LW'(0))   begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    checks++; if (bus.busy_err !== 1'b0)  begin errors++; $display("FAIL reset_busy_err: got %b want 0", bus.busy_err); end
    checks++; if (bus.tx_count !== 16'h0) begin errors++; $display("FAIL reset_tx_count: got %0d want 0", bus.tx_count); end
    sys_rst  = 1'b0;
    launches = 0;
    @(negedge sys_clk);
  endtask

  task automatic test_single();
    logic [7:0] b;
    int base;
    bit ok;
    b    = 8'($urandom_range(1, 255));
    base = rec_q.size();
    write_byte(b);
    checks++; if (bus.empty !== 1'b0)   begin errors++; $display("FAIL single_empty_n1: got %b want 0", bus.empty); end
    checks++; if (bus.tx_en !== 1'b0)   begin errors++; $display("FAIL single_tx_en_n1: got %b want 0", bus.tx_en); end
    @(negedge sys_clk);
    checks++; if (bus.tx_en !== 1'b1)   begin errors++; $display("FAIL single_tx_en_n2: got %b want 1", bus.tx_en); end
    checks++; if (bus.tx_din !== b)     begin errors++; $display("FAIL single_tx_din: got %h want %h", bus.tx_din, b); end
    launches++;
    wait_rec(base + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_rec_timeout: got %0d bytes want %0d", rec_q.size() - base, 1); end
    else if (rec_q[base] !== b) begin errors++; $display("FAIL single_rec: got %h want %h", rec_q[base], b); end
    checks++; if (rec_dout !== b) begin errors++; $display("FAIL single_rec_dout: got %h want %h", rec_dout, b); end
    checks++; if (bus.tx_count !== exp_cnt(launches)) begin errors++; $display("FAIL single_tx_count: got %0d want %0d", bus.tx_count, exp_cnt(launches)); end
  endtask

  task automatic test_burst();
    logic [7:0] first;
    logic [7:0] data [DEPTH+1];
    int base;
    bit ok;
    base      = rec_q.size();
    hold_busy = 1'b1;
    first     = 8'($urandom);
    write_byte(first);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_first_launch: got no tx_en want tx_en"); end
    launches++;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i <= DEPTH; i++) begin
      data[i]     = 8'($urandom);
      bus.wr_en   = 1'b1;
      bus.wr_data = data[i];
      @(negedge sys_clk);
    end
    bus.wr_en = 1'b0;
    checks++; if (bus.full !== 1'b1)        begin errors++; $display("FAIL burst_full: got %b want 1", bus.full); end
    checks++; if (bus.level !== LW'(DEPTH)) begin errors++; $display("FAIL burst_level: got %0d want %0d", bus.level, DEPTH); end
    hold_busy = 1'b0;
    launches += DEPTH;
    wait_rec(base + DEPTH + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_rec_timeout: got %0d bytes want %0d", rec_q.size() - base, DEPTH + 1); end
    else begin
      checks++; if (rec_q[base] !== first) begin errors++; $display("FAIL burst_rec0: got %h want %h", rec_q[base], first); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (rec_q[base + 1 + i] !== data[i]) begin
          errors++; $display("FAIL burst_rec%0d: got %h want %h", i + 1, rec_q[base + 1 + i], data[i]);
        end
      end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL burst_empty_end: got %b want 1", bus.empty); end
    checks++; if (rec_q.size() !== base + DEPTH + 1) begin errors++; $display("FAIL burst_extra: got %0d bytes want %0d", rec_q.size() - base, DEPTH + 1); end
  endtask

  task automatic test_gap();
    logic [7:0] b0, b1;
    int base, phase, d_cyc, e_cyc;
    bit ok;
    base = rec_q.size();
    b0 = 8'($urandom); b1 = 8'($urandom);
    phase = 0; d_cyc = 0; e_cyc = 0;
    write_byte(b0);
    write_byte(b1);
    for (int i = 0; i < 300 && phase < 4; i++) begin
      case (phase)
        0: if (bus.tx_en)    phase = 1;
        1: if (bus.tx_busy)  phase = 2;
        2: if (!bus.tx_busy) begin d_cyc = cyc; phase = 3; end
        default: if (bus.tx_en) begin
          e_cyc = cyc; phase = 4;
          checks++; if (bus.tx_din !== b1) begin errors++; $display("FAIL gap_tx_din: got %h want %h", bus.tx_din, b1); end
        end
      endcase
      if (phase < 4) @(negedge sys_clk);
    end
    checks++;
    if (phase != 4) begin errors++; $display("FAIL gap_second_launch: got phase %0d want 4", phase); end
    else if (e_cyc - d_cyc - 1 != GAP + 1) begin
      errors++; $display("FAIL gap_idle_cycles: got %0d want %0d", e_cyc - d_cyc - 1, GAP + 1);
    end
    launches += 2;
    wait_rec(base + 2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gap_rec_timeout: got %0d bytes want 2", rec_q.size() - base); end
    else if (rec_q[base] !== b0 || rec_q[base + 1] !== b1) begin
      errors++; $display("FAIL gap_rec: got %h %h want %h %h", rec_q[base], rec_q[base + 1], b0, b1);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b, b2;
    int base;
    bit ok;
    stuck = 1'b1;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    write_byte(b);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_launch: got no tx_en want tx_en"); end
    launches++;
    repeat (TMO) @(negedge sys_clk);
    checks++; if (bus.busy_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", bus.busy_err); end
    @(negedge sys_clk);
    checks++; if (bus.busy_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1", bus.busy_err); end
    stuck = 1'b0;
    base  = rec_q.size();
    write_byte(b2);
    launches++;
    wait_rec(base + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_next_timeout: got %0d bytes want 1", rec_q.size() - base); end
    else if (rec_q[base] !== b2) begin errors++; $display("FAIL timeout_next_rec: got %h want %h", rec_q[base], b2); end
    checks++; if (bus.busy_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", bus.busy_err); end
  endtask

  task automatic test_flush();
    logic [7:0] d [4];
    int base, en_seen;
    bit ok;
    base = rec_q.size();
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      bus.wr_en = 1'b1; bus.wr_data = d[i];
      @(negedge sys_clk);
    end
    bus.wr_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.tx_busy) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL flush_busy_seen: got 0 want 1"); end
    launches++;
    @(negedge sys_clk);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
    @(negedge sys_clk);
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    checks++; if (bus.level !== LW'(0)) begin errors++; $display("FAIL flush_level: got %0d want 0", bus.level); end
    checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
    wait_rec(base + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_rec_timeout: got %0d bytes want 1", rec_q.size() - base); end
    else if (rec_q[base] !== d[0]) begin errors++; $display("FAIL flush_rec: got %h want %h", rec_q[base], d[0]); end
    en_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tx_en) en_seen++;
      @(negedge sys_clk);
    end
    checks++; if (en_seen != 0) begin errors++; $display("FAIL flush_no_launch: got %0d tx_en want 0", en_seen); end
    checks++; if (bus.tx_count !== exp_cnt(launches)) begin errors++; $display("FAIL flush_tx_count: got %0d want %0d", bus.tx_count, exp_cnt(launches)); end
  endtask

  task automatic test_reset_mid();
    int en_seen;
    bit ok;
    stuck = 1'b1;
    write_byte(8'($urandom_range(1, 255)));
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_launch: got no tx_en want tx_en"); end
    @(negedge sys_clk);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    #2 sys_rst = 1'b1;
    #1;
    checks++; if (bus.tx_en !== 1'b0)     begin errors++; $display("FAIL rstmid_tx_en: got %b want 0", bus.tx_en); end
    checks++; if (bus.tx_din !== 8'h00)   begin errors++; $display("FAIL rstmid_tx_din: got %h want 00", bus.tx_din); end
    checks++; if (bus.busy_err !== 1'b0)  begin errors++; $display("FAIL rstmid_busy_err: got %b want 0", bus.busy_err); end
    checks++; if (bus.level !== LW'(0))   begin errors++; $display("FAIL rstmid_level: got %0d want 0", bus.level); end
    checks++; if (bus.empty !== 1'b1)     begin errors++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0)      begin errors++; $display("FAIL rstmid_full: got %b want 0", bus.full); end
    checks++; if (bus.tx_count !== 16'h0) begin errors++; $display("FAIL rstmid_tx_count: got %0d want 0", bus.tx_count); end
    @(negedge sys_clk);
    sys_rst  = 1'b0;
    stuck    = 1'b0;
    launches = 0;
    en_seen  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (bus.tx_en) en_seen++;
    end
    checks++; if (en_seen != 0) begin errors++; $display("FAIL rstmid_no_relaunch: got %0d tx_en want 0", en_seen); end
  endtask

  task automatic test_protocol();
    checks++; if (dbl_en != 0) begin errors++; $display("FAIL tx_en_back_to_back: got %0d double pulses want 0", dbl_en); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_gap();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-buffering front end for the `uart_tx` serializer. It accepts bytes from a producer through a write strobe into an internal FIFO. It launches them one at a time into `uart_tx` through the `tx_en`/`tx_din`/`tx_busy` handshake, with an optional inter-byte gap. It sits directly upstream of `uart_tx`, so software or datapath logic can burst bytes without tracking serializer occupancy.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `GAP_CYCLES`, 0: idle clocks inserted after `tx_busy` falls, before the next launch.
- `BUSY_TIMEOUT`, 16: clocks allowed after `tx_en` for `tx_busy` to rise.

Ports:
- `sys_clk` in 1: system clock; single clock domain.
- `sys_rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe.
- `wr_data` in 8: byte to queue.
- `flush` in 1: synchronous FIFO clear.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `tx_en` out 1: one-cycle launch pulse to `uart_tx`.
- `tx_din` out 8: byte presented to `uart_tx`.
- `tx_busy` in 1: busy from `uart_tx`.
- `busy_err` out 1: sticky flag; set on busy timeout.
- `tx_count` out 16: bytes launched (see Configuration).

## Operation
- Write: accepted when `wr_en && !full && !flush`. A write while full is dropped silently; `level` is unchanged.
- FSM states and transitions:
  - IDLE: goes to LAUNCH when `!empty`.
  - LAUNCH: exactly one cycle. Drives `tx_en=1`, registers the head byte into `tx_din`, pops the FIFO, then goes to WAIT_BUSY.
  - WAIT_BUSY: goes to WAIT_DONE on `tx_busy=1`. If `BUSY_TIMEOUT` cycles elapse with `tx_busy=0`, sets `busy_err` and goes to IDLE; the byte is considered lost.
  - WAIT_DONE: on `tx_busy=0`, goes to GAP if `GAP_CYCLES>0`, else to IDLE.
  - GAP: counts `GAP_CYCLES` clocks, then goes to IDLE.
- Push and pop in the same cycle: both take effect and `level` is unchanged. When full, the push is rejected even if a pop occurs that cycle.
- Pointers wrap modulo `DEPTH`. `level` saturates at `DEPTH` and never underflows.
- `flush`:
  - Clears the pointers and sets `level` to 0 on the next edge.
  - Does not abort a byte already launched; the FSM continues through WAIT_BUSY/WAIT_DONE/GAP.
  - A flush asserted in the same cycle as LAUNCH does not undo that pop.
  - `flush` wins over a same-cycle `wr_en`.
- `busy_err` clears only on reset.
- Reset mid-transfer: the FSM returns to IDLE and the FIFO empties. `uart_tx` may still finish its current frame; the feeder waits in IDLE, and since the FIFO is empty no relaunch occurs.

## Timing
- Reset values: `tx_en=0`, `tx_din=8'h00`, `full=0`, `empty=1`, `level=0`, `busy_err=0`, `tx_count=0`, state IDLE.
- `tx_en` and `tx_din` are registered outputs. `tx_din` is stable from the LAUNCH cycle until the FSM next leaves IDLE.
- `full`, `empty` and `level` are registered and reflect all pushes/pops up to the previous edge.
- Latency into an empty, idle feeder: `wr_en` high in cycle N, `empty` low in N+1, `tx_en` high in cycle N+2.
- Back-to-back bytes: the next `tx_en` comes no earlier than `GAP_CYCLES`+1 cycles after the cycle in which `tx_busy` is sampled low in WAIT_DONE.
- `tx_en` is never high for two consecutive cycles.
- `tx_en` is never asserted while the FSM is outside LAUNCH.

## Configuration
- Macro `UART_TX_FEEDER_CNT_EN`.
- Defined: `tx_count` increments by 1 on each LAUNCH cycle and wraps from 16'hFFFF to 0. Reset and `flush` do not interact, except that reset clears it.
- Undefined: no counter logic is built and `tx_count` is tied to 16'h0000.

## Structure
- Shared package `uart_pkg`: FSM state enum `feeder_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP) and byte width constant `UART_DATA_W=8`.
- Sub-module `uart_sync_fifo` (parameters DEPTH, WIDTH; ports push, pop, flush, din, dout, full, empty, level). It is reusable on the receive side.
- `uart_tx_feeder` holds only the FSM, the timers and the counter.

## Test plan
- Single byte: write 8'hA5 into the idle feeder -> `tx_en` pulses at N+2 with `tx_din=8'hA5`. A `uart_tx` model in loopback delivers 8'hA5 at `rec_dout`. `tx_count=1`.
- Burst and full: write 17 bytes 8'h00..8'h10 with `DEPTH=16` while `tx_busy` is held high -> `full=1`. The 17th byte (8'h10) is dropped. Releasing busy yields 8'h00..8'h0F in order, and `empty=1` at the end.
- Gap: with `GAP_CYCLES=5`, two queued bytes -> exactly 6 cycles from `tx_busy` falling to the second `tx_en`.
- Timeout: `tx_busy` stuck at 0, one byte written -> `busy_err=1` exactly `BUSY_TIMEOUT` cycles after WAIT_BUSY is entered. The FSM returns to IDLE and the next byte still launches.
- Flush and reset: queue 4 bytes, assert `flush` during the first byte's WAIT_DONE -> the first byte completes, `level=0`, no further `tx_en`. Assert `sys_rst` mid-WAIT_BUSY -> all outputs return to their reset values asynchronously.
